ifetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the TLB and consumes its instruction-side result. It owns the PC, drives the TLB virtual address, and bypasses the TLB for kseg0/kseg1. It issues a request/acknowledge instruction-bus read and delivers either the fetched word or a fetch exception (AdEL/TLBL) to decode over a valid/ready handshake.

---
 rtl/ifetch_pkg.sv | 23 ++
 rtl/ifetch_if.sv | 46 ++++
 rtl/fetch_addr_xlate.sv | 40 ++++
 rtl/ifetch_unit.sv | 131 +++++++++++++
 tb/tb_ifetch_unit.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
// Exception codes, segment decode constants and FSM states.
package ifetch_pkg;

  localparam logic [4:0]  EXC_ADEL      = 5'd4;
  localparam logic [4:0]  EXC_TLBL      = 5'd2;
  localparam logic [1:0]  KSEG01_TAG    = 2'b10;
  localparam logic [31:0] UNMAPPED_MASK = 32'h1FFF_FFFF;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    DRAIN,
    HALT
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] phys;
    logic        exc;
    logic [4:0]  code;
  } xlate_t;

endpackage

// File: rtl/ifetch_if.sv
// Instruction bus and fetch-to-decode slot handshake bundle.
// master = fetch unit side, slave = bus/decode side.
interface ifetch_if;

  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_ack_i;
  logic [31:0] ibus_rdata_i;

  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        exc_o;
  logic [4:0]  exc_code_o;
  logic [31:0] bad_vaddr_o;

  modport master (
    output ibus_req_o,
    output ibus_addr_o,
    input  ibus_ack_i,
    input  ibus_rdata_i,
    output inst_valid_o,
    input  inst_ready_i,
    output inst_o,
    output inst_pc_o,
    output exc_o,
    output exc_code_o,
    output bad_vaddr_o
  );

  modport slave (
    input  ibus_req_o,
    input  ibus_addr_o,
    output ibus_ack_i,
    output ibus_rdata_i,
    input  inst_valid_o,
    output inst_ready_i,
    input  inst_o,
    input  inst_pc_o,
    input  exc_o,
    input  exc_code_o,
    input  bad_vaddr_o
  );

endinterface

// File: rtl/fetch_addr_xlate.sv
// PC translation and fetch exception check (combinational).
// kseg0/kseg1 bypass the TLB; AdEL outranks TLBL.
module fetch_addr_xlate
  import ifetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        user_mode,
  input  logic [31:0] tlb_phys,
  input  logic        tlb_miss,
  output xlate_t      res
);

  logic unmapped;
  logic adel;
  logic tlbl;

  assign unmapped = (pc[31:30] == KSEG01_TAG);
  assign adel     = (pc[1:0] != 2'b00) ||
                    (user_mode && pc[31]);
  assign tlbl     = !adel && !unmapped && tlb_miss;

  always_comb begin
    res.phys = unmapped ? (pc & UNMAPPED_MASK)
                        : tlb_phys;
    res.exc  = 1'b0;
    res.code = '0;
    unique case (1'b1)
      adel: begin
        res.exc  = 1'b1;
        res.code = EXC_ADEL;
      end
      tlbl: begin
        res.exc  = 1'b1;
        res.code = EXC_TLBL;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, issues one bus read
// at a time and hands words or fetch faults to decode.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        user_mode_i,
  output logic [31:0] ins_addr_virt_o,
  input  logic [31:0] ins_addr_phy_i,
  input  logic        ins_miss_i,
  ifetch_if.master    bus
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic         req_q;
  logic [31:0]  addr_q;
  logic         vld_q;
  logic [31:0]  inst_q;
  logic [31:0]  ipc_q;
  logic         exc_q;
  logic [4:0]   code_q;
  logic [31:0]  bad_q;
  xlate_t       xl;
  logic         slot_free;

  fetch_addr_xlate u_xlate (
    .pc        (pc_q),
    .user_mode (user_mode_i),
    .tlb_phys  (ins_addr_phy_i),
    .tlb_miss  (ins_miss_i),
    .res       (xl)
  );

  assign slot_free = !vld_q || bus.inst_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= '0;
      vld_q   <= 1'b0;
      inst_q  <= '0;
      ipc_q   <= '0;
      exc_q   <= 1'b0;
      code_q  <= '0;
      bad_q   <= '0;
    end else begin
      if (vld_q && bus.inst_ready_i)
        vld_q <= 1'b0;
      unique case (state_q)
        FETCH: begin
          if (redirect_i) begin
            pc_q  <= redirect_pc_i;
            vld_q <= 1'b0;
          end else if (slot_free) begin
            if (xl.exc) begin
              vld_q   <= 1'b1;
              exc_q   <= 1'b1;
              code_q  <= xl.code;
              bad_q   <= pc_q;
              ipc_q   <= pc_q;
              inst_q  <= '0;
              state_q <= HALT;
            end else begin
              // latch phys so TLB updates cannot move the request
              req_q   <= 1'b1;
              addr_q  <= xl.phys;
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus.ibus_ack_i) begin
            req_q   <= 1'b0;
            state_q <= FETCH;
            if (redirect_i) begin
              pc_q  <= redirect_pc_i;
              vld_q <= 1'b0;
            end else begin
              vld_q  <= 1'b1;
              inst_q <= bus.ibus_rdata_i;
              ipc_q  <= pc_q;
              exc_q  <= 1'b0;
              pc_q   <= pc_q + 32'd4;
            end
          end else if (redirect_i) begin
            pc_q    <= redirect_pc_i;
            vld_q   <= 1'b0;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (redirect_i) begin
            pc_q  <= redirect_pc_i;
            vld_q <= 1'b0;
          end
          if (bus.ibus_ack_i) begin
            req_q   <= 1'b0;
            state_q <= FETCH;
          end
        end
        HALT: begin
          if (redirect_i) begin
            pc_q    <= redirect_pc_i;
            vld_q   <= 1'b0;
            state_q <= FETCH;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  assign ins_addr_virt_o  = pc_q;
  assign bus.ibus_req_o   = req_q;
  assign bus.ibus_addr_o  = addr_q;
  assign bus.inst_valid_o = vld_q;
  assign bus.inst_o       = inst_q;
  assign bus.inst_pc_o    = ipc_q;
  assign bus.exc_o        = exc_q;
  assign bus.exc_code_o   = code_q;
  assign bus.bad_vaddr_o  = bad_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit with a transaction-level
// model of PC flow, a TLB stub, a memory responder and decode.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        user_mode_i;
  logic [31:0] virt;
  logic [31:0] phy;
  logic        miss;

  ifetch_if bus ();

  ifetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .user_mode_i     (user_mode_i),
    .ins_addr_virt_o (virt),
    .ins_addr_phy_i  (phy),
    .ins_miss_i      (miss),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [19:0] tlb_xor;
  logic        miss_en;
  logic [19:0] miss_vpn;
  logic        hold_ready;
  int          force_dly;

  assign phy  = {virt[31:12] ^ tlb_xor, virt[11:0]};
  assign miss = miss_en && (virt[31:12] == miss_vpn);

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        exc;
    logic [4:0]  code;
    logic [31:0] bad;
  } slot_t;

  slot_t       exp_slots[$];
  logic [31:0] exp_addrs[$];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] ref_phys(logic [31:0] p);
    if (p[31:30] == 2'b10)
      return {3'b000, p[28:0]};
    return {p[31:12] ^ tlb_xor, p[11:0]};
  endfunction

  function automatic int ref_exc(logic [31:0] p, logic um);
    if (p[1:0] != 2'b00 || (um && p[31]))
      return 4;
    if (p[31:30] != 2'b10 && miss_en && p[31:12] == miss_vpn)
      return 2;
    return 0;
  endfunction

  // k slots are consumed; the fetch after them is issued
  // but left unconsumed until the next redirect.
  task automatic plan(logic [31:0] p0, int k);
    logic [31:0] p;
    slot_t s;
    int e;
    p = p0;
    for (int j = 0; j <= k; j++) begin
      e = ref_exc(p, user_mode_i);
      if (e != 0) begin
        if (j < k) begin
          s.inst = '0; s.pc = p; s.exc = 1'b1;
          s.code = 5'(e); s.bad = p;
          exp_slots.push_back(s);
        end
        break;
      end
      exp_addrs.push_back(ref_phys(p));
      if (j < k) begin
        s.inst = mem_word(ref_phys(p)); s.pc = p;
        s.exc = 1'b0; s.code = '0; s.bad = '0;
        exp_slots.push_back(s);
      end
      p = p + 32'd4;
    end
  endtask

  task automatic do_redirect(logic [31:0] p);
    redirect_pc_i = p;
    redirect_i    = 1'b1;
    @(negedge clk);
    redirect_i    = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_slots.size() != 0 || exp_addrs.size() != 0)
           && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL drain_timeout: slots %0d addrs %0d left, required 0",
               exp_slots.size(), exp_addrs.size());
      exp_slots.delete();
      exp_addrs.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic seg(logic [31:0] p, logic um, logic [19:0] xr,
                     logic men, logic [19:0] mvpn, int k);
    user_mode_i = um;
    tlb_xor     = xr;
    miss_en     = men;
    miss_vpn    = mvpn;
    do_redirect(p);
    plan(p, k);
    wait_drain();
  endtask

  // decode side: accept only while a slot is expected
  logic  rdy;
  slot_t got;
  always @(negedge clk) begin
    rdy = rst_n && !hold_ready && exp_slots.size() > 0 &&
          ($urandom_range(0, 3) != 0);
    bus.inst_ready_i = rdy;
    if (bus.inst_valid_o && rdy) begin
      got = exp_slots.pop_front();
      chk("slot_pc", bus.inst_pc_o, got.pc);
      chk("slot_exc", 32'(bus.exc_o), 32'(got.exc));
      if (got.exc) begin
        chk("slot_code", 32'(bus.exc_code_o), 32'(got.code));
        chk("slot_bad", bus.bad_vaddr_o, got.bad);
        chk("slot_inst0", bus.inst_o, 32'h0);
      end else begin
        chk("slot_inst", bus.inst_o, got.inst);
      end
    end
  end

  // bus side: check each request, ack after a random delay
  logic        req_seen = 1'b0;
  logic [31:0] req_addr;
  int          dly;
  always @(negedge clk) begin
    if (bus.ibus_req_o && !req_seen) begin
      req_seen = 1'b1;
      req_addr = bus.ibus_addr_o;
      if (exp_addrs.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req: addr %h, required no request",
                 bus.ibus_addr_o);
      end else begin
        chk("req_addr", bus.ibus_addr_o, exp_addrs.pop_front());
      end
    end else if (bus.ibus_req_o) begin
      chk("addr_hold", bus.ibus_addr_o, req_addr);
    end
    if (!bus.ibus_req_o) begin
      req_seen = 1'b0;
      bus.ibus_ack_i = 1'b0;
      dly = (force_dly >= 0) ? force_dly : $urandom_range(0, 3);
    end else if (dly == 0) begin
      bus.ibus_ack_i   = 1'b1;
      bus.ibus_rdata_i = mem_word(bus.ibus_addr_o);
    end else begin
      bus.ibus_ack_i = 1'b0;
      dly--;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p;
    logic [31:0] hold_inst;
    logic [31:0] hold_pc;
    int n;
    rst_n         = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    user_mode_i   = 1'b0;
    tlb_xor       = '0;
    miss_en       = 1'b0;
    miss_vpn      = '0;
    hold_ready    = 1'b0;
    force_dly     = -1;
    repeat (3) @(negedge clk);

    chk("rst_pc", virt, 32'hBFC0_0000);
    chk("rst_req", 32'(bus.ibus_req_o), 32'h0);
    chk("rst_addr", bus.ibus_addr_o, 32'h0);
    chk("rst_valid", 32'(bus.inst_valid_o), 32'h0);
    chk("rst_inst", bus.inst_o, 32'h0);
    chk("rst_ipc", bus.inst_pc_o, 32'h0);
    chk("rst_exc", 32'(bus.exc_o), 32'h0);
    chk("rst_code", 32'(bus.exc_code_o), 32'h0);
    chk("rst_bad", bus.bad_vaddr_o, 32'h0);

    // boot from kseg1: requests 1FC0_0000, 1FC0_0004, ...
    plan(32'hBFC0_0000, 3);
    rst_n = 1'b1;
    wait_drain();

    seg(32'h7F00_A230, 1'b0, 20'h7F00A ^ 20'h23333,
        1'b0, 20'h0, 2);
    seg(32'h0000_F324, 1'b0, 20'h0, 1'b1, 20'h0000F, 2);
    repeat (10) @(negedge clk);
    seg(32'h8000_0002, 1'b0, 20'h0, 1'b0, 20'h0, 1);
    seg(32'h8000_0000, 1'b1, 20'h0, 1'b0, 20'h0, 1);
    user_mode_i = 1'b0;

    // redirect while a slow ack is outstanding
    force_dly = 3;
    do_redirect(32'h8000_0400);
    exp_addrs.push_back(32'h0000_0400);
    n = 0;
    while (exp_addrs.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_req_high", 32'(bus.ibus_req_o), 32'h1);
    do_redirect(32'h8000_1000);
    force_dly = -1;
    chk("drain_req_held", 32'(bus.ibus_req_o), 32'h1);
    plan(32'h8000_1000, 2);
    wait_drain();

    // decode back-pressure
    hold_ready = 1'b1;
    do_redirect(32'h8000_2000);
    plan(32'h8000_2000, 1);
    n = 0;
    while (!bus.inst_valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("stall_valid", 32'(bus.inst_valid_o), 32'h1);
    hold_inst = bus.inst_o;
    hold_pc   = bus.inst_pc_o;
    repeat (4) begin
      @(negedge clk);
      chk("stall_inst", bus.inst_o, hold_inst);
      chk("stall_pc", bus.inst_pc_o, hold_pc);
      chk("stall_noreq", 32'(bus.ibus_req_o), 32'h0);
    end
    hold_ready = 1'b0;
    n = 0;
    while (bus.inst_valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_on_consume", 32'(bus.ibus_req_o), 32'h1);
    wait_drain();

    repeat (40) begin
      p = $urandom;
      case ($urandom_range(0, 3))
        0: p[31] = 1'b0;
        1: p[31:29] = 3'b100;
        2: p[31:29] = 3'b101;
        default: p[31:30] = 2'b11;
      endcase
      if ($urandom_range(0, 5) != 0)
        p[1:0] = 2'b00;
      seg(p, ($urandom_range(0, 3) == 0), 20'($urandom),
          ($urandom_range(0, 2) == 0),
          p[31:12] + 20'($urandom_range(0, 1)),
          $urandom_range(1, 5));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
